// File: rtl/core_pkg.sv
// Shared RV32I encodings for the core plus the instruction-encoder request types.
// Field packers and the encoder FSM import these so opcode and funct values live in one place.
package core_pkg;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_I_ALU = 7'b0010011,
    OP_R     = 7'b0110011,
    OP_B     = 7'b1100011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Values match the B-type funct3 field directly.
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_cond_t;

  typedef enum logic [1:0] {
    ENC_R      = 2'd0,
    ENC_I_ALU  = 2'd1,
    ENC_BRANCH = 2'd2,
    ENC_LI     = 2'd3
  } enc_kind_t;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_B = 2'd2,
    FMT_U = 2'd3
  } fmt_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LO_PEND = 1'b1
  } enc_state_t;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [2:0] alu_funct3(alu_op_t op);
    case (op)
      ALU_ADD, ALU_SUB: return F3_ADD_SUB;
      ALU_SLL:          return F3_SLL;
      ALU_SLT:          return F3_SLT;
      ALU_SLTU:         return F3_SLTU;
      ALU_XOR:          return F3_XOR;
      ALU_SRL, ALU_SRA: return F3_SRL_SRA;
      ALU_OR:           return F3_OR;
      ALU_AND:          return F3_AND;
      default:          return F3_ADD_SUB;
    endcase
  endfunction

  function automatic logic [6:0] alu_funct7(alu_op_t op);
    return (op == ALU_SUB || op == ALU_SRA) ? F7_ALT : F7_ZERO;
  endfunction

  function automatic logic alu_legal(alu_op_t op);
    return op <= ALU_AND;
  endfunction

  function automatic logic alu_is_shift(alu_op_t op);
    return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  endfunction

endpackage

// File: rtl/instr_encoder_fmt_pack.sv
// Combinational RV32I field packer for R/I/B/U formats.
// Callers pre-shape the immediate (shamt/funct7 for shifts, upper 20 bits for U).
module rv_fmt_pack
  import core_pkg::*;
(
  input  fmt_t        fmt,
  input  opcode_t     opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs structured operation requests into RV32I words for the debug injection port.
// LI macros needing more than 12 bits expand into a back-to-back LUI+ADDI pair.
module instr_encoder
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  enc_kind_t    req_kind,
  input  alu_op_t      req_alu_op,
  input  branch_cond_t req_cond,
  input  logic [4:0]   req_rd,
  input  logic [4:0]   req_rs1,
  input  logic [4:0]   req_rs2,
  input  logic [31:0]  req_imm,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr,
  output logic         instr_last,
  output logic         err,
  output enc_state_t   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // producer holding valid keeps its payload stable until that edge.
  enc_state_t  state_q, state_d;
  fmt_t        fmt;
  opcode_t     opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  p_rd, p_rs1, p_rs2;
  logic [31:0] p_imm;
  logic [31:0] packed_word;
  logic        bad, two_word, last_d, accept, load_word;
  logic        fits12, fits13;
  logic [19:0] li_hi;
  logic [4:0]  pend_rd;
  logic [11:0] pend_lo;

  assign req_ready = (state_q == ST_IDLE) && (!instr_valid || instr_ready);
  assign accept    = req_valid && req_ready;
  assign dbg_state = state_q;

  assign fits12 = (req_imm == {{20{req_imm[11]}}, req_imm[11:0]});
  assign fits13 = (req_imm == {{19{req_imm[12]}}, req_imm[12:0]});
  // (imm + 0x800) >> 12 without carrying the unused low bits around.
  assign li_hi  = req_imm[31:12] + {19'b0, req_imm[11]};

  always_comb begin
    fmt      = FMT_I;
    opcode   = OP_I_ALU;
    f3       = F3_ADD_SUB;
    f7       = F7_ZERO;
    p_rd     = req_rd;
    p_rs1    = req_rs1;
    p_rs2    = req_rs2;
    p_imm    = req_imm;
    bad      = 1'b0;
    two_word = 1'b0;
    last_d   = 1'b1;
    if (state_q == ST_LO_PEND) begin
      p_rd  = pend_rd;
      p_rs1 = pend_rd;
      p_imm = {20'b0, pend_lo};
    end else begin
      case (req_kind)
        ENC_R: begin
          fmt    = FMT_R;
          opcode = OP_R;
          f3     = alu_funct3(req_alu_op);
          f7     = alu_funct7(req_alu_op);
          bad    = !alu_legal(req_alu_op);
        end
        ENC_I_ALU: begin
          f3 = alu_funct3(req_alu_op);
          if (!alu_legal(req_alu_op) || req_alu_op == ALU_SUB) begin
            bad = 1'b1;
          end else if (alu_is_shift(req_alu_op)) begin
            p_imm = {20'b0, alu_funct7(req_alu_op), req_imm[4:0]};
            bad   = (req_imm[31:5] != 27'd0);
          end else begin
            bad = !fits12;
          end
        end
        ENC_BRANCH: begin
          fmt    = FMT_B;
          opcode = OP_B;
          f3     = req_cond;
          bad    = req_imm[0] || !fits13 || req_cond == 3'b010 || req_cond == 3'b011;
        end
        ENC_LI: begin
          if (req_rd == 5'd0) begin
            p_rs1 = 5'd0;
            p_imm = 32'd0;
          end else if (fits12) begin
            p_rs1 = 5'd0;
          end else begin
            fmt      = FMT_U;
            opcode   = OP_LUI;
            p_imm    = {li_hi, 12'b0};
            two_word = (req_imm[11:0] != 12'd0);
            last_d   = !two_word;
          end
        end
        default: bad = 1'b1;
      endcase
    end
    load_word = (accept && !bad) || (state_q == ST_LO_PEND && instr_ready);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && !bad && two_word) state_d = ST_LO_PEND;
      ST_LO_PEND: if (instr_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  rv_fmt_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .funct3 (f3),
    .funct7 (f7),
    .rd     (p_rd),
    .rs1    (p_rs1),
    .rs2    (p_rs2),
    .imm    (p_imm),
    .word   (packed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_last  <= 1'b0;
      err         <= 1'b0;
      pend_rd     <= '0;
      pend_lo     <= '0;
    end else begin
      err <= accept && bad;
      if (load_word) begin
        instr       <= packed_word;
        instr_last  <= last_d;
        instr_valid <= 1'b1;
      end else if (instr_ready) begin
        instr_valid <= 1'b0;
      end
      if (accept && two_word) begin
        pend_rd <= req_rd;
        pend_lo <= req_imm[11:0];
      end
    end
  end

endmodule
